// File: rtl/time_set_ctrl_pkg.sv
// Shared constants for the time-set controller: key codes, FSM encoding,
// display filler codes and BCD field limits.
package time_set_ctrl_pkg;

   localparam logic [3:0] KEY_SET  = 4'd1;
   localparam logic [3:0] KEY_UP   = 4'd2;
   localparam logic [3:0] KEY_DOWN = 4'd3;
   localparam logic [3:0] KEY_OK   = 4'd4;

   localparam logic [3:0] DASH_CODE_DEF  = 4'hA;
   localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_ED_HR   = 3'd1,
      ST_ED_MIN  = 3'd2,
      ST_ED_SEC  = 3'd3,
      ST_WRITE   = 3'd4
   } state_e;

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key, RTC read/write and display signals of the time-set controller.
interface time_set_ctrl_if;

   logic        Value_en;
   logic [3:0]  KEY_Value;
   logic [23:0] rtc_bcd;
   logic        rtc_valid;
   logic        wr_req;
   logic        wr_ack;
   logic [23:0] wr_data;
   logic [31:0] seg_bcd;
   logic        seg_en;
   logic        pm_flag;

   modport master (
      input  Value_en, KEY_Value, rtc_bcd, rtc_valid, wr_ack,
      output wr_req, wr_data, seg_bcd, seg_en, pm_flag
   );

   modport slave (
      output Value_en, KEY_Value, rtc_bcd, rtc_valid, wr_ack,
      input  wr_req, wr_data, seg_bcd, seg_en, pm_flag
   );

endinterface

// File: rtl/time_set_ctrl_bcd_field_step.sv
// Combinational BCD +/-1 on a two-digit field with wrap at a programmable maximum.
module bcd_field_step (
   input  logic [7:0] value,
   input  logic [7:0] max,
   input  logic       dir,
   output logic [7:0] next
);

   logic legal;

   always_comb begin
      legal = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
      next  = 8'h00;
      // Out-of-range inputs snap to the wrap target of the step direction.
      if (dir) begin
         if (!legal || value == max)
            next = 8'h00;
         else if (value[3:0] == 4'd9)
            next = {value[7:4] + 4'd1, 4'd0};
         else
            next = {value[7:4], value[3:0] + 4'd1};
      end else begin
         if (!legal || value == 8'h00)
            next = max;
         else if (value[3:0] == 4'd0)
            next = {value[7:4] - 4'd1, 4'd9};
         else
            next = {value[7:4], value[3:0] - 4'd1};
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Key-driven time-set controller: shadows the RTC, edits hh/mm/ss with blink
// and inactivity timeout, and writes the edited value back to the RTC.
//
// state     | meaning
// ST_RUN    | follow RTC, wait for SET
// ST_ED_HR  | editing hours (blinking)
// ST_ED_MIN | editing minutes (blinking)
// ST_ED_SEC | editing seconds (blinking)
// ST_WRITE  | wr_req held until wr_ack
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BLINK_MS   = 250,
   parameter int unsigned TIMEOUT_S  = 10,
   parameter logic [3:0]  BLANK_CODE = BLANK_CODE_DEF,
   parameter logic [3:0]  DASH_CODE  = DASH_CODE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   time_set_ctrl_if.master        bus
);

   localparam longint unsigned TO_CYC = 64'(TIMEOUT_S) * 64'(CLK_FREQ);
   localparam longint unsigned BL_CYC = (64'(BLINK_MS) * 64'(CLK_FREQ)) / 64'd1000;
   localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
   localparam int BL_W = (BL_CYC > 1) ? $clog2(BL_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_CYC - 1);
   localparam logic [BL_W-1:0] BL_LOAD = BL_W'(BL_CYC - 1);

   state_e            state_q, state_d;
   logic [23:0]       shadow_q, shadow_d;
   logic              wr_req_q, wr_req_d;
   logic [23:0]       wr_data_q, wr_data_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [BL_W-1:0]   bl_cnt_q, bl_cnt_d;
   logic              blank_q, blank_d;
   logic [31:0]       seg_q, seg_d;
   logic              seg_en_q;
   logic              pm_q, pm_d;

   logic              key_ev;
   logic [7:0]        step_val, step_max, step_next;
   logic              step_up;
   logic [7:0]        hh, mm, ss, hr_bin;

   bcd_field_step u_step (
      .value (step_val),
      .max   (step_max),
      .dir   (step_up),
      .next  (step_next)
   );

   always_comb begin
      step_val = shadow_q[7:0];
      step_max = MS_MAX;
      step_up  = (bus.KEY_Value == KEY_UP);
      case (state_q)
         ST_ED_HR: begin
            step_val = shadow_q[23:16];
            step_max = HR_MAX;
         end
         ST_ED_MIN: step_val = shadow_q[15:8];
         default:   step_val = shadow_q[7:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      wr_req_d  = wr_req_q;
      wr_data_d = wr_data_q;
      to_cnt_d  = to_cnt_q;
      bl_cnt_d  = bl_cnt_q;
      blank_d   = blank_q;
      key_ev    = bus.Value_en &&
                  (bus.KEY_Value inside {KEY_SET, KEY_UP, KEY_DOWN, KEY_OK});

      case (state_q)
         ST_RUN: begin
            if (bus.rtc_valid)
               shadow_d = bus.rtc_bcd;
            if (key_ev && bus.KEY_Value == KEY_SET) begin
               state_d  = ST_ED_HR;
               to_cnt_d = TO_LOAD;
               bl_cnt_d = BL_LOAD;
               blank_d  = 1'b0;
            end
         end
         ST_ED_HR, ST_ED_MIN, ST_ED_SEC: begin
            if (key_ev) begin
               to_cnt_d = TO_LOAD;
               bl_cnt_d = BL_LOAD;
               blank_d  = 1'b0;
               case (bus.KEY_Value)
                  KEY_SET: begin
                     if (state_q == ST_ED_HR)       state_d = ST_ED_MIN;
                     else if (state_q == ST_ED_MIN) state_d = ST_ED_SEC;
                     else                           state_d = ST_ED_HR;
                  end
                  KEY_UP, KEY_DOWN: begin
                     if (state_q == ST_ED_HR)       shadow_d[23:16] = step_next;
                     else if (state_q == ST_ED_MIN) shadow_d[15:8]  = step_next;
                     else                           shadow_d[7:0]   = step_next;
                  end
                  default: begin
                     state_d   = ST_WRITE;
                     wr_req_d  = 1'b1;
                     wr_data_d = shadow_q;
                  end
               endcase
            end else if (to_cnt_q == '0) begin
               // Inactivity expiry abandons the edit; the next RTC read overwrites it.
               state_d = ST_RUN;
               blank_d = 1'b0;
            end else begin
               to_cnt_d = to_cnt_q - 1'b1;
               if (bl_cnt_q == '0) begin
                  blank_d  = ~blank_q;
                  bl_cnt_d = BL_LOAD;
               end else begin
                  bl_cnt_d = bl_cnt_q - 1'b1;
               end
            end
         end
         ST_WRITE: begin
            if (bus.wr_ack) begin
               state_d  = ST_RUN;
               wr_req_d = 1'b0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      hh = shadow_q[23:16];
      mm = shadow_q[15:8];
      ss = shadow_q[7:0];
      if (blank_q) begin
         case (state_q)
            ST_ED_HR:  hh = {BLANK_CODE, BLANK_CODE};
            ST_ED_MIN: mm = {BLANK_CODE, BLANK_CODE};
            ST_ED_SEC: ss = {BLANK_CODE, BLANK_CODE};
            default:   hh = shadow_q[23:16];
         endcase
      end
      seg_d  = {hh, DASH_CODE, mm, DASH_CODE, ss};
      hr_bin = {4'd0, shadow_q[23:20]} * 8'd10 + {4'd0, shadow_q[19:16]};
      pm_d   = (hr_bin >= 8'd12);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         shadow_q  <= 24'h000000;
         wr_req_q  <= 1'b0;
         wr_data_q <= 24'h000000;
         to_cnt_q  <= '0;
         bl_cnt_q  <= '0;
         blank_q   <= 1'b0;
         seg_q     <= {8'h00, DASH_CODE, 8'h00, DASH_CODE, 8'h00};
         seg_en_q  <= 1'b0;
         pm_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         wr_req_q  <= wr_req_d;
         wr_data_q <= wr_data_d;
         to_cnt_q  <= to_cnt_d;
         bl_cnt_q  <= bl_cnt_d;
         blank_q   <= blank_d;
         seg_q     <= seg_d;
         seg_en_q  <= 1'b1;
         pm_q      <= pm_d;
      end
   end

   assign bus.wr_req  = wr_req_q;
   assign bus.wr_data = wr_data_q;
   assign bus.seg_bcd = seg_q;
   assign bus.seg_en  = seg_en_q;
   assign bus.pm_flag = pm_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random key/RTC traffic,
// checked against a field-level behavioural model of the time-set controller.
module tb_time_set_ctrl;

   localparam int TO_CYC = 1000;
   localparam int BL_CYC = 8;
   localparam int M_RUN = 0, M_HR = 1, M_MIN = 2, M_SEC = 3, M_WR = 4;

   logic clk;
   logic rst_n;
   time_set_ctrl_if bus();

   time_set_ctrl #(
      .CLK_FREQ   (1000),
      .BLINK_MS   (8),
      .TIMEOUT_S  (1),
      .BLANK_CODE (4'hF),
      .DASH_CODE  (4'hA)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int          m_st, m_k;
   logic [7:0]  m_h, m_m, m_s;
   bit          m_blank, m_wr_req, m_pm, m_en;
   logic [23:0] m_wr_data;
   logic [31:0] m_seg;

   function automatic int num_of(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] bcd_of(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic logic [7:0] fstep(input logic [7:0] v, input int maxn, input bit up);
      int  n;
      bit  legal;
      n = num_of(v);
      legal = (v[7:4] <= 9) && (v[3:0] <= 9) && (n <= maxn);
      if (up) n = (legal && n < maxn) ? n + 1 : 0;
      else    n = (legal && n > 0) ? n - 1 : maxn;
      return bcd_of(n);
   endfunction

   function automatic logic [31:0] seg_of(input logic [7:0] h, input logic [7:0] m,
                                          input logic [7:0] s, input int st, input bit blank);
      logic [7:0] hh, mm, ss;
      hh = h; mm = m; ss = s;
      if (blank && st == M_HR)  hh = 8'hFF;
      if (blank && st == M_MIN) mm = 8'hFF;
      if (blank && st == M_SEC) ss = 8'hFF;
      return {hh, 4'hA, mm, 4'hA, ss};
   endfunction

   task automatic model_reset();
      m_st = M_RUN; m_k = 0; m_h = 0; m_m = 0; m_s = 0; m_blank = 0;
      m_wr_req = 0; m_wr_data = 0; m_seg = 32'h00A00A00; m_pm = 0; m_en = 0;
   endtask

   task automatic model_edge(input bit ven, input logic [3:0] kv, input bit rv,
                             input logic [23:0] rb, input bit ack);
      bit key;
      m_seg = seg_of(m_h, m_m, m_s, m_st, m_blank);
      m_pm  = (num_of(m_h) >= 12);
      m_en  = 1;
      key   = ven && kv >= 1 && kv <= 4;
      case (m_st)
         M_RUN: begin
            if (rv) {m_h, m_m, m_s} = rb;
            if (key && kv == 1) begin m_st = M_HR; m_k = 0; m_blank = 0; end
         end
         M_HR, M_MIN, M_SEC: begin
            if (key) begin
               m_k = 0; m_blank = 0;
               if (kv == 1) m_st = (m_st == M_SEC) ? M_HR : m_st + 1;
               else if (kv == 4) begin
                  m_st = M_WR; m_wr_req = 1; m_wr_data = {m_h, m_m, m_s};
               end else if (m_st == M_HR) m_h = fstep(m_h, 23, kv == 2);
               else if (m_st == M_MIN)    m_m = fstep(m_m, 59, kv == 2);
               else                       m_s = fstep(m_s, 59, kv == 2);
            end else begin
               m_k++;
               if (m_k == TO_CYC) begin m_st = M_RUN; m_blank = 0; end
               else m_blank = ((m_k / BL_CYC) % 2) == 1;
            end
         end
         default: if (ack) begin m_st = M_RUN; m_wr_req = 0; end
      endcase
   endtask

   task automatic tick(input bit ven, input logic [3:0] kv, input bit rv,
                       input logic [23:0] rb, input bit ack);
      bus.Value_en = ven; bus.KEY_Value = kv; bus.rtc_valid = rv;
      bus.rtc_bcd = rb; bus.wr_ack = ack;
      @(posedge clk);
      model_edge(ven, kv, rv, rb, ack);
      @(negedge clk);
      bus.Value_en = 0; bus.rtc_valid = 0; bus.wr_ack = 0;
   endtask

   task automatic key(input logic [3:0] kv);  tick(1, kv, 0, 24'h0, 0); endtask
   task automatic idle();                     tick(0, 4'h0, 0, 24'h0, 0); endtask
   task automatic rtc(input logic [23:0] v);  tick(0, 4'h0, 1, v, 0); endtask

   task automatic apply_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      model_reset();
      repeat (3) @(negedge clk);
      if (bus.seg_bcd !== 32'h00A00A00) begin miscompares++;
         $display("FAIL reset_seg got %h want %h", bus.seg_bcd, 32'h00A00A00); end
      vectors++;
      if (bus.seg_en !== 1'b0 || bus.pm_flag !== 1'b0) begin miscompares++;
         $display("FAIL reset_en_pm got en=%b pm=%b want 0 0", bus.seg_en, bus.pm_flag); end
      vectors++;
      if (bus.wr_req !== 1'b0 || bus.wr_data !== 24'h0) begin miscompares++;
         $display("FAIL reset_wr got req=%b data=%h want 0 000000", bus.wr_req, bus.wr_data); end
      vectors++;
      rst_n = 1;
      idle();
      if (bus.seg_en !== 1'b1) begin miscompares++;
         $display("FAIL seg_en_after_reset got %b want 1", bus.seg_en); end
      vectors++;
   endtask

   task automatic test_rtc_load();
      apply_reset();
      rtc(24'h235958);
      if (bus.seg_bcd !== 32'h00A00A00) begin miscompares++;
         $display("FAIL rtc_load_latency got %h want %h", bus.seg_bcd, 32'h00A00A00); end
      vectors++;
      idle();
      if (bus.seg_bcd !== 32'h23A59A58 || bus.pm_flag !== 1'b1) begin miscompares++;
         $display("FAIL rtc_load got %h pm=%b want 23a59a58 pm=1", bus.seg_bcd, bus.pm_flag); end
      vectors++;
   endtask

   task automatic test_hour_wrap();
      key(1);
      key(2);
      idle();
      if (bus.seg_bcd !== 32'h00A59A58 || bus.pm_flag !== 1'b0) begin miscompares++;
         $display("FAIL hour_up_wrap got %h pm=%b want 00a59a58 pm=0", bus.seg_bcd, bus.pm_flag); end
      vectors++;
      key(3);
      idle();
      if (bus.seg_bcd !== 32'h23A59A58 || bus.pm_flag !== 1'b1) begin miscompares++;
         $display("FAIL hour_down_wrap got %h pm=%b want 23a59a58 pm=1", bus.seg_bcd, bus.pm_flag); end
      vectors++;
   endtask

   task automatic test_min_down();
      apply_reset();
      rtc(24'h120045);
      key(1); key(1);
      key(3); idle();
      if (bus.seg_bcd !== 32'h12A59A45) begin miscompares++;
         $display("FAIL min_down_wrap got %h want 12a59a45", bus.seg_bcd); end
      vectors++;
      key(3); idle();
      if (bus.seg_bcd !== 32'h12A58A45) begin miscompares++;
         $display("FAIL min_down got %h want 12a58a45", bus.seg_bcd); end
      vectors++;
      repeat (12) key(2);
      idle();
      if (bus.seg_bcd !== m_seg || m_seg !== 32'h12A10A45) begin miscompares++;
         $display("FAIL min_up_to_10 got %h want %h", bus.seg_bcd, m_seg); end
      vectors++;
      key(3); idle();
      if (bus.seg_bcd !== 32'h12A09A45) begin miscompares++;
         $display("FAIL min_borrow got %h want 12a09a45", bus.seg_bcd); end
      vectors++;
   endtask

   task automatic test_write();
      apply_reset();
      tick(0, 4'h0, 0, 24'h0, 1);
      if (bus.wr_req !== 1'b0) begin miscompares++;
         $display("FAIL ack_in_run got wr_req=%b want 0", bus.wr_req); end
      vectors++;
      rtc(24'h081530);
      key(1); key(1); key(1); key(2);
      key(4); idle();
      if (bus.wr_req !== 1'b1 || bus.wr_data !== 24'h081531) begin miscompares++;
         $display("FAIL write_req got req=%b data=%h want 1 081531", bus.wr_req, bus.wr_data); end
      vectors++;
      key(2); key(1); key(3); rtc(24'h111111); idle();
      if (bus.wr_req !== 1'b1 || bus.wr_data !== 24'h081531 || bus.seg_bcd !== 32'h08A15A31)
      begin miscompares++;
         $display("FAIL write_hold got req=%b data=%h seg=%h want 1 081531 08a15a31",
                  bus.wr_req, bus.wr_data, bus.seg_bcd); end
      vectors++;
      tick(0, 4'h0, 0, 24'h0, 1);
      if (bus.wr_req !== 1'b0) begin miscompares++;
         $display("FAIL write_ack got wr_req=%b want 0", bus.wr_req); end
      vectors++;
      rtc(24'h000001); idle();
      if (bus.seg_bcd !== 32'h00A00A01 || bus.wr_data !== 24'h081531) begin miscompares++;
         $display("FAIL back_to_run got seg=%h data=%h want 00a00a01 081531",
                  bus.seg_bcd, bus.wr_data); end
      vectors++;
   endtask

   task automatic test_timeout_blink();
      int dut_blank, mdl_blank;
      bit req_seen;
      dut_blank = 0; mdl_blank = 0; req_seen = 0;
      apply_reset();
      rtc(24'h123456);
      key(1); key(1);
      for (int i = 0; i < TO_CYC + 6; i++) begin
         idle();
         if (bus.seg_bcd === 32'h12AFFA56) dut_blank++;
         if (m_seg == 32'h12AFFA56) mdl_blank++;
         if (bus.wr_req !== 1'b0) req_seen = 1;
         if (bus.seg_bcd !== m_seg) begin miscompares++;
            $display("FAIL blink_cycle %0d got %h want %h", i, bus.seg_bcd, m_seg); end
         vectors++;
      end
      if (dut_blank != mdl_blank || dut_blank == 0) begin miscompares++;
         $display("FAIL blink_count got %0d want %0d", dut_blank, mdl_blank); end
      vectors++;
      if (req_seen) begin miscompares++;
         $display("FAIL timeout_no_write got wr_req asserted want never"); end
      vectors++;
      rtc(24'h010203); idle();
      if (bus.seg_bcd !== 32'h01A02A03) begin miscompares++;
         $display("FAIL timeout_to_run got %h want 01a02a03", bus.seg_bcd); end
      vectors++;
   endtask

   task automatic test_illegal();
      apply_reset();
      rtc(24'h3A7F99); idle();
      if (bus.seg_bcd !== 32'h3AA7FA99 || bus.pm_flag !== m_pm) begin miscompares++;
         $display("FAIL illegal_load got %h pm=%b want 3aa7fa99 pm=%b", bus.seg_bcd, bus.pm_flag, m_pm); end
      vectors++;
      key(1); key(3); idle();
      if (bus.seg_bcd !== 32'h23A7FA99) begin miscompares++;
         $display("FAIL illegal_hr_down got %h want 23a7fa99", bus.seg_bcd); end
      vectors++;
      key(1); key(2); key(1); key(3); idle();
      if (bus.seg_bcd !== m_seg || m_seg !== 32'h23A00A59) begin miscompares++;
         $display("FAIL illegal_min_sec got %h want %h", bus.seg_bcd, m_seg); end
      vectors++;
   endtask

   task automatic test_random();
      bit ven, rv, ack;
      logic [3:0] kv;
      logic [23:0] rb;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         ven = ($urandom_range(5) == 0);
         kv  = 4'($urandom_range(7));
         rv  = ($urandom_range(7) == 0);
         ack = ($urandom_range(5) == 0);
         if ($urandom_range(3) == 0) rb = 24'($urandom);
         else rb = {bcd_of($urandom_range(23)), bcd_of($urandom_range(59)), bcd_of($urandom_range(59))};
         tick(ven, kv, rv, rb, ack);
         if (bus.seg_bcd !== m_seg || bus.pm_flag !== m_pm || bus.seg_en !== m_en ||
             bus.wr_req !== m_wr_req || bus.wr_data !== m_wr_data) begin
            miscompares++;
            $display("FAIL random_%0d got seg=%h pm=%b en=%b req=%b data=%h want %h %b %b %b %h",
                     i, bus.seg_bcd, bus.pm_flag, bus.seg_en, bus.wr_req, bus.wr_data,
                     m_seg, m_pm, m_en, m_wr_req, m_wr_data);
         end
         vectors++;
      end
   endtask

   task automatic test_reset_in_write();
      apply_reset();
      rtc(24'h091011);
      key(1); key(4); idle();
      if (bus.wr_req !== 1'b1) begin miscompares++;
         $display("FAIL pre_reset_write got wr_req=%b want 1", bus.wr_req); end
      vectors++;
      #2 rst_n = 0;
      #1;
      if (bus.wr_req !== 1'b0 || bus.seg_bcd !== 32'h00A00A00) begin miscompares++;
         $display("FAIL async_reset got req=%b seg=%h want 0 00a00a00", bus.wr_req, bus.seg_bcd); end
      vectors++;
      model_reset();
      @(negedge clk);
      rst_n = 1;
      idle();
      if (bus.seg_bcd !== 32'h00A00A00 || bus.wr_req !== 1'b0) begin miscompares++;
         $display("FAIL post_reset got seg=%h req=%b want 00a00a00 0", bus.seg_bcd, bus.wr_req); end
      vectors++;
      rtc(24'h141516); idle();
      if (bus.seg_bcd !== 32'h14A15A16 || bus.pm_flag !== 1'b1) begin miscompares++;
         $display("FAIL post_reset_run got %h pm=%b want 14a15a16 1", bus.seg_bcd, bus.pm_flag); end
      vectors++;
   endtask

   initial begin
      rst_n = 0;
      bus.Value_en = 0; bus.KEY_Value = 0; bus.rtc_bcd = 0;
      bus.rtc_valid = 0; bus.wr_ack = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_rtc_load();
      test_hour_wrap();
      test_min_down();
      test_write();
      test_timeout_blink();
      test_illegal();
      test_random();
      test_reset_in_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired after %0d vectors, want completion", vectors);
      $fatal(1);
   end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, gives the clk frequency in Hz.
REQ-002 Parameter BLINK_MS, default 250, gives the half-period of the edit-field blink in ms.
REQ-003 Parameter TIMEOUT_S, default 10, gives the edit inactivity timeout in seconds.
REQ-004 Parameter BLANK_CODE, default 4'hF, is the digit code that the display decoder renders blank.
REQ-005 Parameter DASH_CODE, default 4'hA, is the filler code for separator digits 2 and 5.
REQ-006 Port clk, input, 1 bit: system clock; the block has one clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port Value_en, input, 1 bit: one-cycle pulse marking KEY_Value as valid.
REQ-009 Port KEY_Value, input, 4 bits: key code; 1=SET, 2=UP, 3=DOWN, 4=OK; other codes are ignored.
REQ-010 Port rtc_bcd, input, 24 bits: {hh,mm,ss} BCD time read from the RTC.
REQ-011 Port rtc_valid, input, 1 bit: one-cycle pulse marking rtc_bcd as valid.
REQ-012 Port wr_req, output, 1 bit: RTC write request, level signal.
REQ-013 Port wr_ack, input, 1 bit: one-cycle pulse that completes a write.
REQ-014 Port wr_data, output, 24 bits: {hh,mm,ss} BCD value to write.
REQ-015 Port seg_bcd, output, 32 bits: {hh,DASH,mm,DASH,ss} digits, 4 bits per digit, MSB digit first.
REQ-016 Port seg_en, output, 1 bit: display enable.
REQ-017 Port pm_flag, output, 1 bit: 1 when the displayed hour is >= 12.

Function
REQ-018 The FSM states SHALL be RUN, ED_HR, ED_MIN, ED_SEC and WRITE.
REQ-019 In RUN, each rtc_valid pulse SHALL load rtc_bcd into the shadow time register {hh,mm,ss}.
- In all other states, rtc_valid SHALL be ignored.
REQ-020 A key event is Value_en=1 together with a legal code; it SHALL be acted on in the same cycle.
- All state and register updates SHALL appear on the next clk edge.
REQ-021 In RUN, SET SHALL go to ED_HR; UP, DOWN and OK SHALL be ignored.
REQ-022 In the edit states, SET SHALL advance the field: ED_HR->ED_MIN->ED_SEC->ED_HR.
REQ-023 In an edit state, UP SHALL increment the selected field in BCD with wrap.
- Hours: 23->00. Minutes and seconds: 59->00.
REQ-024 In an edit state, DOWN SHALL decrement the selected field in BCD with wrap.
- Hours: 00->23. Minutes and seconds: 00->59.
- The low digit SHALL borrow from the tens digit, e.g. 10->09.
REQ-025 In an edit state, OK SHALL go to WRITE and SHALL load wr_data from the shadow register.
REQ-026 In WRITE:
- wr_req SHALL be held at 1.
- Key events SHALL be ignored.
- wr_ack SHALL clear wr_req and return to RUN.
- wr_data SHALL stay stable while wr_req=1.
REQ-027 wr_ack received outside WRITE SHALL be ignored.
REQ-028 The inactivity counter SHALL count TIMEOUT_S*CLK_FREQ cycles while in an edit state.
- Any key event SHALL restart it.
- On expiry the FSM SHALL return to RUN with no write; the next rtc_valid then overwrites the edits.
REQ-029 The blink toggle SHALL invert every BLINK_MS*CLK_FREQ/1000 cycles while in an edit state.
- It SHALL reset to the visible phase on every key event and on entering an edit state.
REQ-030 During the blank phase, seg_bcd SHALL show BLANK_CODE on both digits of the selected field.
- All other digits SHALL show the shadow value.
REQ-031 seg_bcd SHALL be registered and SHALL update one cycle after the shadow register or blink phase changes.
REQ-032 seg_en SHALL be 1 in every state once reset is released.
REQ-033 pm_flag SHALL be derived from the shadow hour and registered alongside seg_bcd.
REQ-034 An illegal BCD value on rtc_bcd (a digit > 9, hour > 23, or min/sec > 59) SHALL be loaded unchanged.
- Increment from an illegal value SHALL wrap to 00.
- Decrement from an illegal value SHALL wrap to the field maximum (23 or 59).

Reset
REQ-035 While rst_n=0, the block SHALL hold:
- state RUN and shadow register 00:00:00;
- wr_req=0 and wr_data=0;
- seg_bcd={8'h00,DASH,8'h00,DASH,8'h00}, seg_en=0, pm_flag=0;
- both counters cleared.
REQ-036 Reset asserted during WRITE SHALL drop wr_req asynchronously; the pending write SHALL be discarded.

Structure
REQ-037 A shared package SHALL hold the key code constants, the state encoding, and the DASH and BLANK codes.
REQ-038 BCD increment/decrement with a programmable maximum SHALL be one sub-module, bcd_field_step.
- It SHALL be combinational, with inputs value, max and dir, and output next value.
- It SHALL be instantiated once and muxed onto the selected field.

Verification
REQ-039 Reset, then rtc_valid with rtc_bcd=24'h235958 -> seg_bcd=32'h23A59A58 and pm_flag=1 after 2 cycles.
REQ-040 SET, then UP at hour 23 -> hour 00 and pm_flag=0; DOWN -> hour 23.
REQ-041 SET, SET, DOWN at minute 00 -> minute 59; DOWN again -> 58; minute 10 with DOWN -> 09.
REQ-042 OK in ED_SEC -> wr_req=1 and wr_data equals the shadow value.
- Key events during WRITE leave state and wr_data unchanged.
- wr_ack -> wr_req=0 and state RUN.
REQ-043 Enter ED_MIN and wait TIMEOUT_S (scaled-down parameters) -> state RUN, wr_req never asserted.
- Blink blanks digits 3 and 4 only, with period 2*BLINK_MS.
REQ-044 Drop rst_n during WRITE -> wr_req=0 immediately; after release, state RUN and seg_bcd at its reset value.
